// File: rtl/ir_peak_valley_detector.sv
// Peak/valley tracker with hysteresis for the filtered IR stream: reports peak, valley,
// AC amplitude and beat period. Define PERIOD_AVG_EN to average the last four periods.
module ir_peak_valley_detector #(
  parameter int unsigned DW   = 20,
  parameter int unsigned HYST = 64,
  parameter int unsigned PW   = 12
) (
  input  logic          CLK_Filter,
  input  logic          rst_n,
  input  logic [DW-1:0] Filtered_In,
  input  logic          Sample_Valid,
  output logic [DW-1:0] Peak_Value,
  output logic [DW-1:0] Valley_Value,
  output logic [DW-1:0] AC_Amplitude,
  output logic          AC_Valid,
  output logic          Beat_Pulse,
  output logic [PW-1:0] Period_Out,
  output logic          Period_Valid
);

  localparam int unsigned XW = DW + 1;
  localparam logic [DW:0] HystExt = XW'(HYST);

  typedef enum logic [1:0] {StSeed, StRising, StFalling} state_e;

  state_e        state_q, state_d;
  logic [DW-1:0] run_max_q, run_max_d;
  logic [DW-1:0] run_min_q, run_min_d;
  logic [PW-1:0] cnt_q, cnt_d;
  logic          have_peak_q, have_peak_d;
  logic [DW-1:0] peak_q, peak_d;
  logic [DW-1:0] valley_q, valley_d;
  logic [DW-1:0] ac_q, ac_d;
  logic          ac_valid_q, ac_valid_d;
  logic          beat_q, beat_d;
  logic [PW-1:0] period_q, period_d;
  logic          period_valid_q, period_valid_d;

  logic [DW:0]   x_ext, max_ext, min_ext, peak_ext;
  logic [PW-1:0] cnt_inc;

  // Widened by one bit so adding the hysteresis can never wrap.
  assign x_ext    = {1'b0, Filtered_In};
  assign max_ext  = {1'b0, run_max_q};
  assign min_ext  = {1'b0, run_min_q};
  assign peak_ext = {1'b0, peak_q};
  assign cnt_inc  = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;

  always_comb begin
    state_d        = state_q;
    run_max_d      = run_max_q;
    run_min_d      = run_min_q;
    cnt_d          = cnt_q;
    have_peak_d    = have_peak_q;
    peak_d         = peak_q;
    valley_d       = valley_q;
    ac_d           = ac_q;
    ac_valid_d     = 1'b0;
    beat_d         = 1'b0;
    period_valid_d = 1'b0;

    if (Sample_Valid) begin
      cnt_d = cnt_inc;
      unique case (state_q)
        StSeed: begin
          run_max_d = Filtered_In;
          run_min_d = Filtered_In;
          state_d   = StRising;
        end
        StRising: begin
          if (x_ext > max_ext) begin
            run_max_d = Filtered_In;
          end else if (x_ext + HystExt < max_ext) begin
            peak_d         = run_max_q;
            beat_d         = 1'b1;
            period_valid_d = have_peak_q;
            cnt_d          = '0;
            have_peak_d    = 1'b1;
            run_min_d      = Filtered_In;
            state_d        = StFalling;
          end
        end
        StFalling: begin
          if (x_ext < min_ext) begin
            run_min_d = Filtered_In;
          end else if (x_ext > min_ext + HystExt) begin
            valley_d   = run_min_q;
            ac_d       = (min_ext > peak_ext) ? '0 : peak_q - run_min_q;
            ac_valid_d = 1'b1;
            run_max_d  = Filtered_In;
            state_d    = StRising;
          end
        end
        default: state_d = StSeed;
      endcase
    end
  end

`ifdef PERIOD_AVG_EN
  localparam int unsigned SW = PW + 2;

  logic [PW-1:0] buf_q [4];
  logic [PW-1:0] buf_d [4];
  logic          buf_full_q, buf_full_d;
  logic [SW-1:0] buf_sum;

  // First measured period seeds every slot so the mean starts at that period.
  always_comb begin
    buf_d      = buf_q;
    buf_full_d = buf_full_q;
    period_d   = period_q;
    if (period_valid_d) begin
      if (!buf_full_q) begin
        for (int i = 0; i < 4; i++) buf_d[i] = cnt_inc;
        buf_full_d = 1'b1;
      end else begin
        buf_d[0] = cnt_inc;
        for (int i = 1; i < 4; i++) buf_d[i] = buf_q[i-1];
      end
    end
    buf_sum = SW'(buf_d[0]) + SW'(buf_d[1]) + SW'(buf_d[2]) + SW'(buf_d[3]);
    if (period_valid_d) period_d = PW'(buf_sum >> 2);
  end

  always_ff @(posedge CLK_Filter or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) buf_q[i] <= '0;
      buf_full_q <= 1'b0;
    end else begin
      buf_q      <= buf_d;
      buf_full_q <= buf_full_d;
    end
  end
`else
  always_comb begin
    period_d = period_q;
    if (period_valid_d) period_d = cnt_inc;
  end
`endif

  always_ff @(posedge CLK_Filter or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= StSeed;
      run_max_q      <= '0;
      run_min_q      <= '0;
      cnt_q          <= '0;
      have_peak_q    <= 1'b0;
      peak_q         <= '0;
      valley_q       <= '0;
      ac_q           <= '0;
      ac_valid_q     <= 1'b0;
      beat_q         <= 1'b0;
      period_q       <= '0;
      period_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      run_max_q      <= run_max_d;
      run_min_q      <= run_min_d;
      cnt_q          <= cnt_d;
      have_peak_q    <= have_peak_d;
      peak_q         <= peak_d;
      valley_q       <= valley_d;
      ac_q           <= ac_d;
      ac_valid_q     <= ac_valid_d;
      beat_q         <= beat_d;
      period_q       <= period_d;
      period_valid_q <= period_valid_d;
    end
  end

  assign Peak_Value   = peak_q;
  assign Valley_Value = valley_q;
  assign AC_Amplitude = ac_q;
  assign AC_Valid     = ac_valid_q;
  assign Beat_Pulse   = beat_q;
  assign Period_Out   = period_q;
  assign Period_Valid = period_valid_q;

endmodule
